// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: MSHR entry states and line geometry used by
// the MSHR, the load/store queue and the cache tag logic.
package dcache_pkg;

    localparam int ADDR_BITS        = 32;
    localparam int LINE_BYTES       = 64;
    localparam int LINE_OFFSET_BITS = 6;
    localparam int LINE_ADDR_BITS   = ADDR_BITS - LINE_OFFSET_BITS;
    localparam int LINE_BITS        = LINE_BYTES * 8;

    localparam int N_ENTRIES = 8;
    localparam int IDX_BITS  = 3;

    typedef enum logic [1:0] {
        INVALID,
        PENDING,
        ISSUED,
        FILL
    } mshr_state_t;

endpackage

// File: rtl/mshr_pick_first.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module mshr_pick_first #(
    parameter int N        = 8,
    parameter int IDX_BITS = 3
) (
    input  logic [N-1:0]        req,
    output logic                valid,
    output logic [IDX_BITS-1:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // it unassigned and no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_mshr.sv
// Miss status holding registers for one data-cache bank: merges misses to the
// same line, issues one memory request per line, and pulses fin per fill.
module dcache_mshr #(
    parameter int N_ENTRIES      = dcache_pkg::N_ENTRIES,
    parameter int IDX_BITS       = dcache_pkg::IDX_BITS,
    parameter int LINE_ADDR_BITS = dcache_pkg::LINE_ADDR_BITS,
    parameter int LINE_BITS      = dcache_pkg::LINE_BITS
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      alloc,
    input  logic [LINE_ADDR_BITS-1:0] alloc_line,
    output logic [IDX_BITS-1:0]       wr_idx,
    output logic                      full,

    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [LINE_ADDR_BITS-1:0] mem_req_line,
    output logic [IDX_BITS-1:0]       mem_req_idx,

    input  logic                      mem_rsp_valid,
    input  logic [IDX_BITS-1:0]       mem_rsp_idx,
    input  logic [LINE_BITS-1:0]      mem_rsp_data,

    output logic                      fin,
    output logic [IDX_BITS-1:0]       fin_idx,
    output logic [LINE_ADDR_BITS-1:0] fin_line,
    output logic [LINE_BITS-1:0]      fin_data
);

    import dcache_pkg::*;

    mshr_state_t               state_q [N_ENTRIES];
    mshr_state_t               state_d [N_ENTRIES];
    logic [LINE_ADDR_BITS-1:0] line_q  [N_ENTRIES];

    logic [N_ENTRIES-1:0] free_vec;
    logic [N_ENTRIES-1:0] pend_vec;
    logic [N_ENTRIES-1:0] match_vec;

    logic                 free_valid;
    logic [IDX_BITS-1:0]  free_idx;
    logic                 pend_valid;
    logic [IDX_BITS-1:0]  pend_idx;
    logic                 hit;
    logic [IDX_BITS-1:0]  match_idx;

    logic                 req_hold_q;
    logic [IDX_BITS-1:0]  req_hold_idx_q;
    logic [IDX_BITS-1:0]  req_sel;

    logic                 do_alloc;
    logic                 req_fire;
    logic                 rsp_hit;

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            free_vec[i]  = (state_q[i] == INVALID);
            pend_vec[i]  = (state_q[i] == PENDING);
            match_vec[i] = (state_q[i] != INVALID) && (line_q[i] == alloc_line);
        end
    end

    // Merging guarantees at most one entry holds a given line, so the match
    // vector is one-hot or empty.
    always_comb begin
        hit       = 1'b0;
        match_idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (match_vec[i]) begin
                hit       = 1'b1;
                match_idx = IDX_BITS'(i);
            end
        end
    end

    mshr_pick_first #(
        .N        (N_ENTRIES),
        .IDX_BITS (IDX_BITS)
    ) u_pick_free (
        .req   (free_vec),
        .valid (free_valid),
        .idx   (free_idx)
    );

    mshr_pick_first #(
        .N        (N_ENTRIES),
        .IDX_BITS (IDX_BITS)
    ) u_pick_pend (
        .req   (pend_vec),
        .valid (pend_valid),
        .idx   (pend_idx)
    );

    assign wr_idx   = hit ? match_idx : (free_valid ? free_idx : '0);
    assign full     = !free_valid;
    assign do_alloc = alloc && !hit && free_valid;

    // A stalled request keeps its entry even if a lower-index entry becomes
    // PENDING meanwhile, so line and index stay stable until the handshake.
    assign req_sel       = req_hold_q ? req_hold_idx_q : pend_idx;
    assign mem_req_valid = pend_valid;
    assign mem_req_idx   = pend_valid ? req_sel : '0;
    assign mem_req_line  = pend_valid ? line_q[req_sel] : '0;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_hit = mem_rsp_valid && (state_q[mem_rsp_idx] == ISSUED);

    // The alloc, request and response updates always target entries in
    // different states, so they never collide on one entry.
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            state_d[i] = (state_q[i] == FILL) ? INVALID : state_q[i];
        end
        if (req_fire) begin
            state_d[req_sel] = ISSUED;
        end
        if (rsp_hit) begin
            state_d[mem_rsp_idx] = FILL;
        end
        if (do_alloc) begin
            state_d[free_idx] = PENDING;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                state_q[i] <= INVALID;
            end
            req_hold_q     <= 1'b0;
            req_hold_idx_q <= '0;
            fin            <= 1'b0;
            fin_idx        <= '0;
            fin_line       <= '0;
            fin_data       <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
            end
            req_hold_q     <= mem_req_valid && !mem_req_ready;
            req_hold_idx_q <= req_sel;
            fin            <= rsp_hit;
            if (rsp_hit) begin
                fin_idx  <= mem_rsp_idx;
                fin_line <= line_q[mem_rsp_idx];
                fin_data <= mem_rsp_data;
            end
        end
    end

    // NOTE: line addresses are not reset; an INVALID entry's line is never
    // observed, so clearing this storage would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            line_q[free_idx] <= alloc_line;
        end
    end

endmodule

// File: tb/tb_dcache_mshr.sv
// Randomized and directed bench for dcache_mshr: a behavioural entry model
// predicts combinational outputs; expected fills are queued for a fin monitor.
module tb_dcache_mshr;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int LW = 26;
    localparam int DW = 512;

    localparam int M_FREE      = 0;
    localparam int M_WAIT_REQ  = 1;
    localparam int M_WAIT_FILL = 2;
    localparam int M_FILLING   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc;
    logic [LW-1:0] alloc_line;
    logic [IW-1:0] wr_idx;
    logic          full;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [LW-1:0] mem_req_line;
    logic [IW-1:0] mem_req_idx;
    logic          mem_rsp_valid;
    logic [IW-1:0] mem_rsp_idx;
    logic [DW-1:0] mem_rsp_data;
    logic          fin;
    logic [IW-1:0] fin_idx;
    logic [LW-1:0] fin_line;
    logic [DW-1:0] fin_data;

    always #5 clk = ~clk;

    dcache_mshr dut (
        .clk           (clk),
        .rst           (rst),
        .alloc         (alloc),
        .alloc_line    (alloc_line),
        .wr_idx        (wr_idx),
        .full          (full),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_line  (mem_req_line),
        .mem_req_idx   (mem_req_idx),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_idx   (mem_rsp_idx),
        .mem_rsp_data  (mem_rsp_data),
        .fin           (fin),
        .fin_idx       (fin_idx),
        .fin_line      (fin_line),
        .fin_data      (fin_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what each entry is waiting for, and its line.
    int            m_st   [N];
    logic [LW-1:0] m_line [N];
    bit            m_held;
    int            m_held_idx;

    typedef struct {
        int            idx;
        logic [LW-1:0] line;
        logic [DW-1:0] data;
    } fill_t;

    fill_t fin_q[$];
    fill_t f;
    bit    mon_en = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i]   = M_FREE;
            m_line[i] = '0;
        end
        m_held     = 1'b0;
        m_held_idx = 0;
        fin_q.delete();
    endtask

    // One clock cycle: drive inputs, check predicted combinational outputs,
    // then advance the model across the rising edge.
    task automatic cycle(input bit a, input logic [LW-1:0] al, input bit rdy,
                         input bit rv, input int ri, input logic [DW-1:0] rd, input bit r);
        int match, free, pend, e_wr, e_req;
        bit e_full, e_valid;
        int old [N];
        @(negedge clk);
        rst           = r;
        alloc         = a;
        alloc_line    = al;
        mem_req_ready = rdy;
        mem_rsp_valid = rv;
        mem_rsp_idx   = IW'(ri);
        mem_rsp_data  = rd;
        #1;
        match = -1;
        free  = -1;
        pend  = -1;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] != M_FREE && m_line[i] == al && match < 0) match = i;
            if (m_st[i] == M_FREE && free < 0) free = i;
            if (m_st[i] == M_WAIT_REQ && pend < 0) pend = i;
        end
        e_wr    = (match >= 0) ? match : ((free >= 0) ? free : 0);
        e_full  = (free < 0);
        e_valid = (pend >= 0);
        e_req   = m_held ? m_held_idx : pend;
        check("wr_idx", DW'(wr_idx), DW'(e_wr));
        check("full", DW'(full), DW'(e_full));
        check("mem_req_valid", DW'(mem_req_valid), DW'(e_valid));
        if (e_valid) begin
            check("mem_req_idx", DW'(mem_req_idx), DW'(e_req));
            check("mem_req_line", DW'(mem_req_line), DW'(m_line[e_req]));
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            old = m_st;
            for (int i = 0; i < N; i++) begin
                if (old[i] == M_FILLING) m_st[i] = M_FREE;
            end
            if (e_valid && rdy) begin
                m_st[e_req] = M_WAIT_FILL;
                m_held      = 1'b0;
            end else begin
                m_held = e_valid;
            end
            m_held_idx = e_req;
            if (rv && old[ri] == M_WAIT_FILL) begin
                m_st[ri] = M_FILLING;
                fin_q.push_back('{idx: ri, line: m_line[ri], data: rd});
            end
            if (a && match < 0 && free >= 0) begin
                m_st[free]   = M_WAIT_REQ;
                m_line[free] = al;
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cycle(1'b0, '0, rdy, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic do_alloc(input logic [LW-1:0] line, input bit rdy);
        cycle(1'b1, line, rdy, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic do_rsp(input int idx, input logic [DW-1:0] data, input bit rdy);
        cycle(1'b0, '0, rdy, 1'b1, idx, data, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b1);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Fin monitor: every queued fill must appear exactly in the next cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fin) begin
                if (fin_q.size() == 0) begin
                    check("fin_spurious", DW'(fin), '0);
                end else begin
                    f = fin_q.pop_front();
                    check("fin_idx", DW'(fin_idx), DW'(f.idx));
                    check("fin_line", DW'(fin_line), DW'(f.line));
                    check("fin_data", fin_data, f.data);
                end
            end else if (fin_q.size() > 0) begin
                check("fin_missing", DW'(fin), DW'(1));
                void'(fin_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] a5;
        int            cand[$];
        int            ri;
        bit            rv;

        rst           = 1'b1;
        alloc         = 1'b0;
        alloc_line    = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_idx   = '0;
        mem_rsp_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_fin", DW'(fin), '0);
        check("reset_fin_idx", DW'(fin_idx), '0);
        check("reset_fin_line", DW'(fin_line), '0);
        check("reset_fin_data", fin_data, '0);
        check("reset_mem_req_valid", DW'(mem_req_valid), '0);
        check("reset_mem_req_line", DW'(mem_req_line), '0);
        check("reset_mem_req_idx", DW'(mem_req_idx), '0);
        check("reset_full", DW'(full), '0);
        check("reset_wr_idx", DW'(wr_idx), '0);
        mon_en = 1'b1;

        // First miss, request next cycle, then a merge while ISSUED.
        do_alloc(26'h100, 1'b0);
        idle(1, 1'b1);
        do_alloc(26'h100, 1'b1);
        idle(1, 1'b1);
        do_alloc(26'h140, 1'b1);
        idle(2, 1'b1);

        // Three stalled requests, then drain in index order.
        do_reset();
        do_alloc(26'h200, 1'b0);
        do_alloc(26'h240, 1'b0);
        do_alloc(26'h280, 1'b0);
        idle(5, 1'b0);
        idle(3, 1'b1);

        // Fill of entry 2, merge in its fin cycle, then back-to-back fills.
        a5 = {64{8'hA5}};
        do_rsp(2, a5, 1'b1);
        do_alloc(26'h280, 1'b1);
        do_rsp(0, rand_data(), 1'b1);
        do_rsp(1, rand_data(), 1'b1);
        idle(2, 1'b1);

        // Full MSHR: drop a new line, still merge an existing one.
        do_reset();
        for (int i = 0; i < N; i++) do_alloc(26'h300 + LW'(i), 1'b0);
        do_alloc(26'h3F0, 1'b0);
        do_alloc(26'h305, 1'b0);
        idle(1, 1'b0);

        // Reset with requests outstanding; the late response must be ignored.
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(26'h400 + LW'(i), 1'b1);
        idle(3, 1'b1);
        do_reset();
        do_rsp(1, rand_data(), 1'b0);
        idle(2, 1'b0);
        do_alloc(26'h500, 1'b1);
        idle(2, 1'b1);

        // Random traffic over a small line pool to exercise merges and full.
        for (int c = 0; c < 3000; c++) begin
            cand.delete();
            for (int i = 0; i < N; i++) if (m_st[i] == M_WAIT_FILL) cand.push_back(i);
            rv = 1'b0;
            ri = int'($urandom_range(0, N - 1));
            if (cand.size() > 0 && $urandom_range(0, 99) < 40) begin
                rv = 1'b1;
                ri = cand[$urandom_range(0, cand.size() - 1)];
            end else if ($urandom_range(0, 99) < 8) begin
                rv = 1'b1;
            end
            cycle(bit'($urandom_range(0, 1)),
                  26'h1000 + LW'($urandom_range(0, 11)) * 26'h40,
                  bit'($urandom_range(0, 99) < 55),
                  rv, ri, rand_data(),
                  bit'($urandom_range(0, 499) == 0));
        end
        idle(3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_mshr.md
# dcache_mshr

Miss status holding register file for one data-cache bank; the cache instantiates one for the even bank and one for the odd bank. It tracks up to N_ENTRIES outstanding line misses, merges secondary misses to the same line, issues one memory request per primary miss, and announces each returned fill with a one-cycle `fin` pulse and entry index. The load/store queue records `wr_idx` at allocation and compares it against `fin_idx` to wake waiting operations.

## Interface
- N_ENTRIES, 8, number of MSHR entries
- IDX_BITS, 3, entry index width (log2 N_ENTRIES)
- LINE_ADDR_BITS, 26, line address width (32-bit address, 64 B line)
- LINE_BITS, 512, fill data width

- clk  in  1  clock; everything is sampled on its rising edge
- rst  in  1  synchronous, active-high reset
- alloc  in  1  cache miss this cycle; allocate or merge
- alloc_line  in  LINE_ADDR_BITS  line address of the miss
- wr_idx  out  IDX_BITS  entry the current/next miss maps to (combinational)
- full  out  1  no free entry
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_line  out  LINE_ADDR_BITS  requested line
- mem_req_idx  out  IDX_BITS  tag returned with the response
- mem_rsp_valid  in  1  fill returning; always accepted
- mem_rsp_idx  in  IDX_BITS  entry being filled
- mem_rsp_data  in  LINE_BITS  fill data
- fin  out  1  one-cycle fill-complete pulse
- fin_idx  out  IDX_BITS  entry completing
- fin_line  out  LINE_ADDR_BITS  line being written into the cache
- fin_data  out  LINE_BITS  line data

## Operation
- Per-entry state: INVALID, PENDING (needs a request), ISSUED (waiting for fill), FILL (fin cycle). Each entry also holds a line address.
- Match: `alloc_line` equals the line of an entry in PENDING, ISSUED or FILL.
- `wr_idx` is the matching entry's index if there is a match. Otherwise it is the lowest-index INVALID entry. If there is neither, it is 0.
- On alloc with a match, the request merges; no state changes.
- On alloc with no match and `!full`, entry `wr_idx` goes INVALID→PENDING and stores `alloc_line`.
- On alloc with no match and `full`, the request is dropped. The cache must stall; the block does not retry.
- Request: `mem_req_valid` is high when any entry is PENDING. It presents the lowest-index PENDING entry. Line and index stay stable while `valid && !ready`. On handshake, the entry goes PENDING→ISSUED.
- Response: if `mem_rsp_valid` and entry `mem_rsp_idx` is ISSUED, the entry goes ISSUED→FILL. The data, index and line are registered into the fin outputs. A response to a non-ISSUED entry is ignored.
- FILL lasts exactly one cycle (the fin cycle), then the entry goes to INVALID.
- `full` is high when no entry is INVALID. An entry in FILL counts as occupied.

## Timing
- Reset: all entries INVALID. `fin`, `mem_req_valid` and `full` are 0. `fin_idx`, `fin_line`, `fin_data`, `mem_req_line` and `mem_req_idx` are 0. `wr_idx` is 0.
- Allocation at edge t: the entry is PENDING in cycle t+1. The earliest `mem_req_valid` for it is in cycle t+1.
- Response sampled at edge t: `fin` is high for cycle t+1 only. The entry is INVALID from t+2 and allocatable at edge t+2.
- Alloc matching a FILL entry in its fin cycle: merges, and `wr_idx == fin_idx` in that same cycle. The LSQ therefore marks the operation ready immediately; no new entry is allocated.
- Back-to-back responses to different entries give `fin` on consecutive cycles.
- Alloc and request handshake in the same cycle on different entries both take effect. The same holds for alloc and response.
- Reset mid-operation drops all outstanding entries. Late memory responses then hit INVALID entries and are ignored.
- Handshake rule: `mem_req_valid` never drops without `mem_req_ready`, except on reset.

## Structure
- `dcache_pkg` holds the `mshr_state_t` enum (INVALID, PENDING, ISSUED, FILL) and the line-size constants shared with `lsq` and the cache tag logic.
- One sub-module, `mshr_pick_first`: an N_ENTRIES-bit lowest-set-bit priority encoder returning a valid bit and an index. It is instantiated for free-entry selection and for PENDING selection.

## Test plan
- Reset, then alloc line 0x100: `wr_idx`=0 in the alloc cycle. The next cycle shows `mem_req_valid`=1, `mem_req_line`=0x100, `mem_req_idx`=0.
- Alloc 0x100, then alloc 0x100 again: both allocs see `wr_idx`=0, only one memory request is issued, and entry 1 stays free.
- Hold `mem_req_ready`=0 for 5 cycles with 3 PENDING entries: line and index stay constant. Then the requests drain in index order 0, 1, 2.
- Response idx 2 with data 0xA5…: `fin`=1 and `fin_idx`=2 for exactly one cycle, with `fin_data` equal to the response data. An alloc of that line in the fin cycle gives `wr_idx`=2 and allocates nothing new.
- Fill all 8 entries: `full`=1. A 9th alloc of a new line is dropped and state is unchanged. An alloc matching entry 5 still merges to `wr_idx`=5.
- Reset while 4 entries are ISSUED, then send a response with idx 1: no `fin`, and all entries are INVALID.
